stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control front end for the stopwatch time counter. It debounces the three push-buttons (start/stop, clear, lap) and converts them into single-cycle press events. A Moore state machine (IDLE / COUNT / PAUSE) sequences the counter and drives its 2-bit `cnt_ctrl` command. It also produces a lap-hold flag that the display path uses to freeze the shown time while the counter keeps running.

## Interface
- `DB_CYCLES`, default 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz); benches override with 4.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_start`  in  1  raw start/stop button, active-high, asynchronous to `clk`.
- `btn_clear`  in  1  raw clear button, active-high, asynchronous.
- `btn_lap`  in  1  raw lap button, active-high, asynchronous.
- `cnt_ctrl`  out  2  command to the time counter: 2'b00 IDLE (clear), 2'b01 COUNT, 2'b10 PAUSE; 2'b11 is never driven.
- `lap_hold`  out  1  1 = display shows the frozen lap value; 0 = display shows the live value.
- `running`  out  1  1 exactly while the state is COUNT.

## Operation
- Per button: 2-flop synchronizer -> debouncer -> rising-edge detector.
- Debouncer: holds a debounced level `db` (reset 0) and a counter of width clog2(`DB_CYCLES`)+1.
  - Counter increments each cycle that the synchronized input differs from `db`.
  - Counter clears to 0 in any cycle where they are equal, so glitches shorter than `DB_CYCLES` are rejected.
  - When the counter reaches `DB_CYCLES`-1 while the input still differs, `db` takes the input value and the counter clears.
- Press pulse: 1 for one cycle on each 0->1 transition of `db`; release produces no pulse.
- `start_p`, `clear_p`, `lap_p` denote the three press pulses.
- FSM, state encoding equals the `cnt_ctrl` encoding; `cnt_ctrl` is the state register itself:
  - IDLE: `start_p` -> COUNT. `clear_p` and `lap_p` are ignored.
  - COUNT: `start_p` -> PAUSE. Otherwise `lap_p` toggles `lap_hold`. `clear_p` is ignored (the stopwatch must be paused before it can be cleared).
  - PAUSE: `clear_p` -> IDLE and `lap_hold` <= 0. Otherwise `start_p` -> COUNT. Otherwise `lap_p` sets `lap_hold` <= 0.
- Priority on simultaneous pulses:
  - In PAUSE: clear > start > lap.
  - In COUNT: start > lap; a lap pulse in the same cycle as a start pulse is dropped.
- `lap_hold` is always 0 in IDLE.
- `running` = (state == COUNT), registered together with the state.
- Illegal state 2'b11 (not reachable) recovers to IDLE on the next edge.

## Timing
- Reset values while `rst`=1 and after release: state IDLE, `cnt_ctrl`=2'b00, `lap_hold`=0, `running`=0, all synchronizers/`db`/counters 0, no pulses.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous); any pending debounce count is discarded.
- Latency: raw button rises before edge 0 and stays high -> sync output high after edge 1 -> `db` high after edge `DB_CYCLES`+1 -> pulse high during the cycle after edge `DB_CYCLES`+1 -> state, `cnt_ctrl`, `running`, `lap_hold` update at edge `DB_CYCLES`+2.
- Total: `DB_CYCLES`+2 clocks from first sampling edge to output change.
- A button held high produces exactly one pulse; a new pulse requires the button to be debounced low, then debounced high again.
- Press pulses are exactly 1 cycle; each pulse causes at most one state transition.

## Test plan
- Reset: assert `rst` mid-COUNT -> `cnt_ctrl`=00, `lap_hold`=0, `running`=0 immediately; after release, `btn_start` held for 10 cycles (DB_CYCLES=4) -> `cnt_ctrl`=01 at edge 6 after first sample; held 100 cycles -> stays 01 (no re-toggle).
- Glitch rejection: `btn_start` pulses of 1, 2 and 3 cycles separated by low gaps -> `cnt_ctrl` stays 00; a 4-cycle-stable press -> 01.
- Full sequence: start -> 01; start -> 10; clear -> 00; check `running` tracks 01 only.
- Clear ignored in COUNT and IDLE: clear press in COUNT -> stays 01; in IDLE -> stays 00.
- Lap: in COUNT, lap -> `lap_hold`=1, lap -> 0, lap -> 1; start -> PAUSE with `lap_hold`=1; lap -> 0; lap again -> stays 0; clear -> IDLE with `lap_hold`=0.
- Simultaneous: identical start+clear presses in PAUSE -> IDLE; start+lap presses in COUNT -> PAUSE with `lap_hold` unchanged.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl / stopwatch_debounce
//
// Control front end for the stopwatch time counter. Each raw push-button is
// synchronised, debounced and reduced to a single-cycle press pulse. A Moore
// state machine (IDLE / COUNT / PAUSE) turns those pulses into the 2-bit
// command for the time counter and a lap-hold flag for the display path.
//
// stopwatch_ctrl ports:
//   clk        in   system clock (50 MHz)
//   rst        in   asynchronous, active-high reset
//   btn_start  in   raw start/stop button, active-high, asynchronous
//   btn_clear  in   raw clear button, active-high, asynchronous
//   btn_lap    in   raw lap button, active-high, asynchronous
//   cnt_ctrl   out  counter command: 00 IDLE(clear), 01 COUNT, 10 PAUSE
//   lap_hold   out  1 = display shows frozen lap value, 0 = live value
//   running    out  1 exactly while the state is COUNT
//
// stopwatch_debounce ports:
//   clk, rst   as above
//   din        raw asynchronous button level
//   press      one-cycle pulse on each accepted 0->1 transition
// ---------------------------------------------------------------------------

module stopwatch_debounce #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic press
);

   localparam int CW = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic          db;
   logic          db_d;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser; the raw button is asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= din;
         sync_b <= sync_a;
      end
   end

   // The count only survives while the synchronised level keeps disagreeing
   // with the accepted level, so any bounce shorter than DB_CYCLES restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db  <= 1'b0;
         cnt <= '0;
      end else if (sync_b == db) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         db  <= sync_b;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Delayed copy of the debounced level for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_d <= 1'b0;
      end else begin
         db_d <= db;
      end
   end

   assign press = db & ~db_d;

endmodule

module stopwatch_ctrl #(
   parameter int DB_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic       btn_lap,
   output logic [1:0] cnt_ctrl,
   output logic       lap_hold,
   output logic       running
);

   // State encoding doubles as the counter command, so cnt_ctrl is the
   // state register itself and needs no decode.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      PAUSE = 2'b10
   } state_t;

   state_t state;
   logic   start_p;
   logic   clear_p;
   logic   lap_p;

   stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
      .clk   (clk),
      .rst   (rst),
      .din   (btn_start),
      .press (start_p)
   );

   stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
      .clk   (clk),
      .rst   (rst),
      .din   (btn_clear),
      .press (clear_p)
   );

   stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
      .clk   (clk),
      .rst   (rst),
      .din   (btn_lap),
      .press (lap_p)
   );

   // Sequencing FSM. Clear is only honoured while paused, so a running
   // stopwatch cannot be wiped by accident. In COUNT a lap pulse arriving
   // together with start is dropped; in PAUSE clear beats start beats lap.
   // The unreachable 2'b11 pattern falls back to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         lap_hold <= 1'b0;
         running  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               lap_hold <= 1'b0;
               if (start_p) begin
                  state   <= COUNT;
                  running <= 1'b1;
               end
            end
            COUNT: begin
               if (start_p) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end else if (lap_p) begin
                  lap_hold <= ~lap_hold;
               end
            end
            PAUSE: begin
               if (clear_p) begin
                  state    <= IDLE;
                  lap_hold <= 1'b0;
               end else if (start_p) begin
                  state   <= COUNT;
                  running <= 1'b1;
               end else if (lap_p) begin
                  lap_hold <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               lap_hold <= 1'b0;
               running  <= 1'b0;
            end
         endcase
      end
   end

   assign cnt_ctrl = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Bench for stopwatch_ctrl with DB_CYCLES = 4. Directed steps follow the
// stopwatch use cases, then a randomized phase drives arbitrary button
// patterns. A reference model predicts the outputs from button history:
// a button level is accepted once the synchronised input has shown the
// opposite level for DB consecutive cycles, an accepted rise is a press,
// and presses are applied to an abstract stopwatch mode.
// ---------------------------------------------------------------------------

module tb_stopwatch_ctrl;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_clear = 1'b0;
   logic       btn_lap = 1'b0;
   logic [1:0] cnt_ctrl;
   logic       lap_hold;
   logic       running;

   int checks = 0;
   int errors = 0;

   // Reference model state: mode 0 = stopped/cleared, 1 = timing, 2 = paused.
   int          m_mode;
   logic        m_lap;
   logic [2:0]  m_db;
   logic [2:0]  m_dbp;
   logic [31:0] m_hist [3];

   stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_clear (btn_clear),
      .btn_lap   (btn_lap),
      .cnt_ctrl  (cnt_ctrl),
      .lap_hold  (lap_hold),
      .running   (running)
   );

   // 100 MHz-style bench clock; absolute period is irrelevant to the design.
   always #5 clk = ~clk;

   function automatic logic [1:0] modeCode(input int mode);
      case (mode)
         1:       return 2'b01;
         2:       return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic resetModel();
      m_mode = 0;
      m_lap  = 1'b0;
      m_db   = '0;
      m_dbp  = '0;
      for (int b = 0; b < 3; b++) m_hist[b] = '0;
   endtask

   // One clock edge of the model. Bit i of m_hist is the raw level sampled
   // i edges ago; the synchroniser delays it by two edges, so the level
   // seen by the debouncer over its last DB cycles is bits 2..DB+1.
   task automatic modelStep(input logic s, input logic c, input logic l);
      logic [2:0] raw;
      logic [2:0] pulse;
      logic       flip;
      pulse = m_db & ~m_dbp;
      if (m_mode == 0) begin
         if (pulse[0]) m_mode = 1;
      end else if (m_mode == 1) begin
         if (pulse[0]) m_mode = 2;
         else if (pulse[2]) m_lap = ~m_lap;
      end else begin
         if (pulse[1]) begin
            m_mode = 0;
            m_lap  = 1'b0;
         end else if (pulse[0]) begin
            m_mode = 1;
         end else if (pulse[2]) begin
            m_lap = 1'b0;
         end
      end
      m_dbp = m_db;
      raw = {l, c, s};
      for (int b = 0; b < 3; b++) begin
         m_hist[b] = {m_hist[b][30:0], raw[b]};
         flip = 1'b1;
         for (int i = 2; i <= DB + 1; i++) begin
            if (m_hist[b][i] == m_db[b]) flip = 1'b0;
         end
         if (flip) m_db[b] = ~m_db[b];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] exp_ctrl,
                              input logic exp_lap, input logic exp_run);
      checks++;
      assert (cnt_ctrl === exp_ctrl) else begin
         errors++;
         $error("[TB] FAIL %s cnt_ctrl: observed %b expected %b", tag, cnt_ctrl, exp_ctrl);
      end
      checks++;
      assert (lap_hold === exp_lap) else begin
         errors++;
         $error("[TB] FAIL %s lap_hold: observed %b expected %b", tag, lap_hold, exp_lap);
      end
      checks++;
      assert (running === exp_run) else begin
         errors++;
         $error("[TB] FAIL %s running: observed %b expected %b", tag, running, exp_run);
      end
   endtask

   // Called at a negedge; holds the buttons for n edges, checking the model
   // after each edge, and returns at the following negedge.
   task automatic applyStimulus(input logic s, input logic c, input logic l, input int n);
      btn_start = s;
      btn_clear = c;
      btn_lap   = l;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         modelStep(s, c, l);
         #1;
         checkOutput("model", modeCode(m_mode), m_lap, m_mode == 1);
         @(negedge clk);
      end
   endtask

   task automatic pressButtons(input logic s, input logic c, input logic l);
      applyStimulus(s, c, l, 8);
      applyStimulus(1'b0, 1'b0, 1'b0, 8);
   endtask

   task automatic doReset();
      rst = 1'b1;
      #1;
      checkOutput("async_reset", 2'b00, 1'b0, 1'b0);
      btn_start = 1'b0;
      btn_clear = 1'b0;
      btn_lap   = 1'b0;
      resetModel();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int hold;
      logic [2:0] r;

      resetModel();
      #1 rst = 1'b1;
      #1;
      checkOutput("reset_hold", 2'b00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 4);
      checkOutput("after_reset", 2'b00, 1'b0, 1'b0);

      // Reset while counting returns outputs to idle immediately.
      pressButtons(1'b1, 1'b0, 1'b0);
      checkOutput("count_before_reset", 2'b01, 1'b0, 1'b1);
      doReset();

      // Start latency: first sampling edge is index 0, outputs move at edge 6.
      btn_start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1);
         checkOutput("start_latency", (i >= 6) ? 2'b01 : 2'b00, 1'b0, i >= 6);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 100);
      checkOutput("start_held", 2'b01, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 8);

      // Glitch rejection from idle.
      doReset();
      for (int w = 1; w <= 3; w++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, w);
         applyStimulus(1'b0, 1'b0, 1'b0, 6);
         checkOutput("glitch", 2'b00, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, DB);
      applyStimulus(1'b0, 1'b0, 1'b0, 8);
      checkOutput("stable_press", 2'b01, 1'b0, 1'b1);

      // Full sequence and clear being ignored outside PAUSE.
      pressButtons(1'b0, 1'b1, 1'b0);
      checkOutput("clear_in_count", 2'b01, 1'b0, 1'b1);
      pressButtons(1'b1, 1'b0, 1'b0);
      checkOutput("pause", 2'b10, 1'b0, 1'b0);
      pressButtons(1'b0, 1'b1, 1'b0);
      checkOutput("clear_in_pause", 2'b00, 1'b0, 1'b0);
      pressButtons(1'b0, 1'b1, 1'b0);
      checkOutput("clear_in_idle", 2'b00, 1'b0, 1'b0);

      // Lap handling.
      pressButtons(1'b1, 1'b0, 1'b0);
      pressButtons(1'b0, 1'b0, 1'b1);
      checkOutput("lap_1", 2'b01, 1'b1, 1'b1);
      pressButtons(1'b0, 1'b0, 1'b1);
      checkOutput("lap_2", 2'b01, 1'b0, 1'b1);
      pressButtons(1'b0, 1'b0, 1'b1);
      checkOutput("lap_3", 2'b01, 1'b1, 1'b1);
      pressButtons(1'b1, 1'b0, 1'b0);
      checkOutput("pause_lap_kept", 2'b10, 1'b1, 1'b0);
      pressButtons(1'b0, 1'b0, 1'b1);
      checkOutput("lap_in_pause", 2'b10, 1'b0, 1'b0);
      pressButtons(1'b0, 1'b0, 1'b1);
      checkOutput("lap_in_pause_again", 2'b10, 1'b0, 1'b0);
      pressButtons(1'b0, 1'b1, 1'b0);
      checkOutput("clear_after_lap", 2'b00, 1'b0, 1'b0);

      // Simultaneous presses.
      pressButtons(1'b1, 1'b0, 1'b0);
      pressButtons(1'b1, 1'b0, 1'b0);
      pressButtons(1'b1, 1'b1, 1'b0);
      checkOutput("start_clear_pause", 2'b00, 1'b0, 1'b0);
      pressButtons(1'b1, 1'b0, 1'b0);
      pressButtons(1'b0, 1'b0, 1'b1);
      pressButtons(1'b1, 1'b0, 1'b1);
      checkOutput("start_lap_count", 2'b10, 1'b1, 1'b0);
      pressButtons(1'b0, 1'b1, 1'b0);

      // Randomized button activity against the model.
      for (int seg = 0; seg < 300; seg++) begin
         if ($urandom_range(0, 39) == 0) begin
            doReset();
         end else begin
            r[0] = ($urandom_range(0, 2) == 0);
            r[1] = ($urandom_range(0, 3) == 0);
            r[2] = ($urandom_range(0, 2) == 0);
            hold = int'($urandom_range(1, 10));
            applyStimulus(r[0], r[1], r[2], hold);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety net so the run always ends even if a step stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
